axi_addr_remap_ctrl: RTL and testbench
======================================

Name: axi_addr_remap_ctrl

Overview:
Controller that drives the translated AW/AR addresses of the address-modifier stage from a small programmable remap rule table. It also sequences rule updates safely. When a rule update is requested, it stops admitting new AW/AR transactions, drains all outstanding ones (tracked via B and R-last), applies the update atomically, then resumes. It sits beside the address modifier: it observes the slave-side AW/AR addresses and the handshakes on all five channels, and gates only AW/AR valid/ready.

Parameters:
AddrWidthIn, 32, width of the incoming address.
AddrWidthOut, 32, width of the translated address.
NumRules, 4, number of remap rules (≥1).
MaxTxns, 8, maximum outstanding transactions per direction (≥1).

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
aw_addr_i  in  AddrWidthIn  slave-side AW address
ar_addr_i  in  AddrWidthIn  slave-side AR address
aw_addr_o  out  AddrWidthOut  translated AW address
ar_addr_o  out  AddrWidthOut  translated AR address
slv_aw_valid_i / slv_aw_ready_o  in/out  1  slave-side AW handshake
mst_aw_valid_o / mst_aw_ready_i  out/in  1  master-side AW handshake
slv_ar_valid_i / slv_ar_ready_o  in/out  1  slave-side AR handshake
mst_ar_valid_o / mst_ar_ready_i  out/in  1  master-side AR handshake
b_valid_i, b_ready_i  in  1 each  B handshake observation
r_valid_i, r_ready_i, r_last_i  in  1 each  R handshake observation
cfg_valid_i  in  1  rule update request
cfg_ready_o  out  1  rule update accepted (applied)
cfg_idx_i  in  $clog2(NumRules) (min 1)  rule index
cfg_en_i  in  1  rule enable
cfg_base_i, cfg_mask_i  in  AddrWidthIn  match base and mask
cfg_offset_i  in  AddrWidthOut  output base
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, rst_i=1): all rules disabled (en=0, base/mask/offset=0); aw_cnt=ar_cnt=0; state IDLE; aw_hold=ar_hold=0; cfg_ready_o=0; busy_o=0.
- Translation (combinational, 0 latency), applied to AW and AR independently. Rule k matches when en[k] and (addr & mask[k]) == (base[k] & mask[k]). The lowest matching index wins. On a match, out = offset[k] | resize(addr & ~mask[k]). With no match, out = resize(addr). resize truncates MSBs or zero-extends to AddrWidthOut.
- Gating, per channel X∈{aw,ar}:
  - open_X = (state==IDLE && !cfg_valid_i && X_cnt<MaxTxns) || X_hold.
  - mst_X_valid_o = slv_X_valid_i & open_X.
  - slv_X_ready_o = mst_X_ready_i & open_X.
- X_hold: set when mst_X_valid_o=1 and mst_X_ready_i=0; cleared on handshake. Once asserted, a master-side valid is never revoked.
- Counters:
  - aw_cnt: +1 on AW handshake; −1 on b_valid&b_ready.
  - ar_cnt: +1 on AR handshake; −1 on r_valid&r_ready&r_last.
  - Simultaneous +1 and −1 leaves the counter unchanged.
  - A decrement at 0 holds 0 and fires a simulation assertion.
  - Counter width is $clog2(MaxTxns+1).
- FSM:
  - IDLE: cfg_valid_i → DRAIN.
  - DRAIN: when aw_cnt==0, ar_cnt==0, aw_hold==0 and ar_hold==0 → APPLY.
  - APPLY: cfg_ready_o=1 for exactly this cycle; the rule at cfg_idx_i is written at the clock edge; → IDLE.
  - cfg_* must be held stable while cfg_valid_i=1 until cfg_ready_o. The new rule is visible from the first IDLE cycle after APPLY.
- cfg_idx_i ≥ NumRules: the update is handshaken but the write is dropped.
- cfg_valid_i deasserted during DRAIN (protocol violation): assertion fires; the FSM still completes and writes the held values.
- Reset mid-DRAIN/APPLY: returns to IDLE and clears the table; no partial write.

Test Plan:
- Reset, rules empty, AW addr 0x1234_5678 → aw_addr_o=0x1234_5678; AW passes same cycle; aw_cnt=1; after B handshake aw_cnt=0.
- Program rule0 base=0x8000_0000, mask=0xF000_0000, offset=0x2000_0000. Then AR addr 0x8000_0010 → ar_addr_o=0x2000_0010. AR addr 0x9000_0010 → passes unchanged.
- Two overlapping enabled rules (idx1, idx2) both matching 0x4000_0000 → idx1 offset is used.
- AR outstanding with no R-last, then cfg_valid_i → busy_o=1; new AW/AR blocked; cfg_ready_o stays 0 until R-last handshake. APPLY comes 1 cycle after the counters reach 0, then traffic resumes.
- mst_aw_ready_i held 0 while AW valid, then cfg_valid_i rises → mst_aw_valid_o stays 1 until handshake; only then does DRAIN progress.
- MaxTxns=2: three back-to-back ARs with no R → third stalled (slv_ar_ready_o=0) until one R-last; rst_i pulse mid-DRAIN → IDLE, counters 0, cfg_ready_o 0.

Source files
------------

// File: rtl/axi_addr_remap_ctrl.sv
// rtl/axi_addr_remap_ctrl.sv - AW/AR address remap rule table with drain-before-update sequencing
// Rule writes are applied only after all outstanding AW/AR transactions have drained.
module axi_addr_remap_ctrl #(
  parameter int AddrWidthIn  = 32,
  parameter int AddrWidthOut = 32,
  parameter int NumRules     = 4,
  parameter int MaxTxns      = 8,
  localparam int IdxW        = (NumRules > 1) ? $clog2(NumRules) : 1,
  localparam int CntW        = $clog2(MaxTxns + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [AddrWidthIn-1:0]  aw_addr_i,
  input  logic [AddrWidthIn-1:0]  ar_addr_i,
  output logic [AddrWidthOut-1:0] aw_addr_o,
  output logic [AddrWidthOut-1:0] ar_addr_o,
  input  logic                    slv_aw_valid_i,
  output logic                    slv_aw_ready_o,
  output logic                    mst_aw_valid_o,
  input  logic                    mst_aw_ready_i,
  input  logic                    slv_ar_valid_i,
  output logic                    slv_ar_ready_o,
  output logic                    mst_ar_valid_o,
  input  logic                    mst_ar_ready_i,
  input  logic                    b_valid_i,
  input  logic                    b_ready_i,
  input  logic                    r_valid_i,
  input  logic                    r_ready_i,
  input  logic                    r_last_i,
  input  logic                    cfg_valid_i,
  output logic                    cfg_ready_o,
  input  logic [IdxW-1:0]         cfg_idx_i,
  input  logic                    cfg_en_i,
  input  logic [AddrWidthIn-1:0]  cfg_base_i,
  input  logic [AddrWidthIn-1:0]  cfg_mask_i,
  input  logic [AddrWidthOut-1:0] cfg_offset_i,
  output logic                    busy_o
);

  typedef enum logic [1:0] {IDLE, DRAIN, APPLY} state_e;

  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTxns);

  state_e                  state_q, state_d;
  logic [NumRules-1:0]     rule_en;
  logic [AddrWidthIn-1:0]  rule_base   [NumRules];
  logic [AddrWidthIn-1:0]  rule_mask   [NumRules];
  logic [AddrWidthOut-1:0] rule_offset [NumRules];
  logic [CntW-1:0]         aw_cnt, ar_cnt;
  logic                    aw_hold, ar_hold;
  logic                    aw_open, ar_open;
  logic                    aw_inc, aw_dec, ar_inc, ar_dec;

  // Scan from the top index down so the lowest matching rule overrides the rest.
  function automatic logic [AddrWidthOut-1:0] remap(input logic [AddrWidthIn-1:0] addr);
    remap = AddrWidthOut'(addr);
    for (int k = NumRules - 1; k >= 0; k--) begin
      if (rule_en[k] && ((addr & rule_mask[k]) == (rule_base[k] & rule_mask[k])))
        remap = rule_offset[k] | AddrWidthOut'(addr & ~rule_mask[k]);
    end
  endfunction

  assign aw_addr_o = remap(aw_addr_i);
  assign ar_addr_o = remap(ar_addr_i);

  // A pending master-side valid keeps its channel open so it is never withdrawn.
  assign aw_open = (state_q == IDLE && !cfg_valid_i && aw_cnt < MaxCnt) || aw_hold;
  assign ar_open = (state_q == IDLE && !cfg_valid_i && ar_cnt < MaxCnt) || ar_hold;

  assign mst_aw_valid_o = slv_aw_valid_i & aw_open;
  assign slv_aw_ready_o = mst_aw_ready_i & aw_open;
  assign mst_ar_valid_o = slv_ar_valid_i & ar_open;
  assign slv_ar_ready_o = mst_ar_ready_i & ar_open;

  assign aw_inc = mst_aw_valid_o & mst_aw_ready_i;
  assign aw_dec = b_valid_i & b_ready_i;
  assign ar_inc = mst_ar_valid_o & mst_ar_ready_i;
  assign ar_dec = r_valid_i & r_ready_i & r_last_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_hold <= 1'b0;
      ar_hold <= 1'b0;
    end else begin
      aw_hold <= mst_aw_valid_o & ~mst_aw_ready_i;
      ar_hold <= mst_ar_valid_o & ~mst_ar_ready_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_cnt <= '0;
      ar_cnt <= '0;
    end else begin
      case ({aw_inc, aw_dec})
        2'b10:   aw_cnt <= aw_cnt + 1'b1;
        2'b01:   if (aw_cnt != '0) aw_cnt <= aw_cnt - 1'b1;
        default: aw_cnt <= aw_cnt;
      endcase
      case ({ar_inc, ar_dec})
        2'b10:   ar_cnt <= ar_cnt + 1'b1;
        2'b01:   if (ar_cnt != '0) ar_cnt <= ar_cnt - 1'b1;
        default: ar_cnt <= ar_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cfg_ready_o = 1'b0;
    case (state_q)
      IDLE:  if (cfg_valid_i) state_d = DRAIN;
      DRAIN: if (aw_cnt == '0 && ar_cnt == '0 && !aw_hold && !ar_hold) state_d = APPLY;
      APPLY: begin
        cfg_ready_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);

  // Out-of-range indices complete the handshake but leave the table untouched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rule_en <= '0;
      for (int k = 0; k < NumRules; k++) begin
        rule_base[k]   <= '0;
        rule_mask[k]   <= '0;
        rule_offset[k] <= '0;
      end
    end else if (state_q == APPLY && int'(cfg_idx_i) < NumRules) begin
      rule_en[cfg_idx_i]     <= cfg_en_i;
      rule_base[cfg_idx_i]   <= cfg_base_i;
      rule_mask[cfg_idx_i]   <= cfg_mask_i;
      rule_offset[cfg_idx_i] <= cfg_offset_i;
    end
  end

  a_aw_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(aw_dec && !aw_inc && aw_cnt == '0));
  a_ar_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(ar_dec && !ar_inc && ar_cnt == '0));
  a_cfg_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == DRAIN) |-> cfg_valid_i);

endmodule

// File: tb/tb_axi_addr_remap_ctrl.sv
// tb/tb_axi_addr_remap_ctrl.sv - directed vector bench for axi_addr_remap_ctrl
module tb_axi_addr_remap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] aw_addr, ar_addr, aw_addr_o, ar_addr_o;
  logic        slv_aw_valid, slv_aw_ready, mst_aw_valid, mst_aw_ready;
  logic        slv_ar_valid, slv_ar_ready, mst_ar_valid, mst_ar_ready;
  logic        b_valid, b_ready, r_valid, r_ready, r_last;
  logic        cfg_valid, cfg_ready, cfg_en, busy;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_base, cfg_mask, cfg_offset;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] aw;
    logic [31:0] ar;
    logic [31:0] exp_aw;
    logic [31:0] exp_ar;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  axi_addr_remap_ctrl #(
    .AddrWidthIn(32), .AddrWidthOut(32), .NumRules(3), .MaxTxns(2)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .aw_addr_i(aw_addr), .ar_addr_i(ar_addr),
    .aw_addr_o(aw_addr_o), .ar_addr_o(ar_addr_o),
    .slv_aw_valid_i(slv_aw_valid), .slv_aw_ready_o(slv_aw_ready),
    .mst_aw_valid_o(mst_aw_valid), .mst_aw_ready_i(mst_aw_ready),
    .slv_ar_valid_i(slv_ar_valid), .slv_ar_ready_o(slv_ar_ready),
    .mst_ar_valid_o(mst_ar_valid), .mst_ar_ready_i(mst_ar_ready),
    .b_valid_i(b_valid), .b_ready_i(b_ready),
    .r_valid_i(r_valid), .r_ready_i(r_ready), .r_last_i(r_last),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_idx_i(cfg_idx), .cfg_en_i(cfg_en),
    .cfg_base_i(cfg_base), .cfg_mask_i(cfg_mask), .cfg_offset_i(cfg_offset),
    .busy_o(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic wait_cfg(input string name);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = cfg_ready;
    end
    check(name, {31'd0, ok}, 32'd1);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] idx, input logic en, input logic [31:0] base,
                         input logic [31:0] mask, input logic [31:0] off);
    cfg_idx = idx; cfg_en = en; cfg_base = base; cfg_mask = mask; cfg_offset = off;
    cfg_valid = 1'b1;
  endtask

  task automatic program_rule(input logic [1:0] idx, input logic en, input logic [31:0] base,
                              input logic [31:0] mask, input logic [31:0] off);
    step();
    set_cfg(idx, en, base, mask, off);
    wait_cfg("cfg_handshake");
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      step();
      aw_addr = vecs[i].aw;
      ar_addr = vecs[i].ar;
      samp();
      check($sformatf("vec%0d_aw", i), aw_addr_o, vecs[i].exp_aw);
      check($sformatf("vec%0d_ar", i), ar_addr_o, vecs[i].exp_ar);
    end
  endtask

  initial begin
    vecs[0] = '{32'h1234_5678, 32'h8000_0010, 32'h1234_5678, 32'h2000_0010};
    vecs[1] = '{32'h4000_0000, 32'h9000_0010, 32'hA000_0000, 32'h9000_0010};
    vecs[2] = '{32'h4100_0004, 32'h41FF_0000, 32'hA100_0004, 32'hA1FF_0000};
    vecs[3] = '{32'h8ABC_DEF0, 32'h0000_0000, 32'h2ABC_DEF0, 32'h0000_0000};
    vecs[4] = '{32'h4000_0000, 32'h4000_1234, 32'hB000_0000, 32'hB000_1234};
    vecs[5] = '{32'h4100_0004, 32'h8000_0010, 32'h4100_0004, 32'h2000_0010};
    vecs[6] = '{32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF};
    vecs[7] = '{32'h40FF_FFFF, 32'h8FFF_FFFF, 32'hB0FF_FFFF, 32'h2FFF_FFFF};

    rst = 1'b1;
    aw_addr = '0; ar_addr = '0;
    slv_aw_valid = 0; mst_aw_ready = 0; slv_ar_valid = 0; mst_ar_ready = 0;
    b_valid = 0; b_ready = 0; r_valid = 0; r_ready = 0; r_last = 0;
    cfg_valid = 0; cfg_idx = '0; cfg_en = 0; cfg_base = '0; cfg_mask = '0; cfg_offset = '0;
    step(); step();
    rst = 1'b0;

    // Reset state and pass-through with an empty table
    samp();
    check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_aw_cnt", 32'(dut.aw_cnt), 32'd0);
    step();
    aw_addr = 32'h1234_5678; slv_aw_valid = 1; mst_aw_ready = 1;
    samp();
    check("empty_aw_addr", aw_addr_o, 32'h1234_5678);
    check("empty_mst_aw_valid", {31'd0, mst_aw_valid}, 32'd1);
    check("empty_slv_aw_ready", {31'd0, slv_aw_ready}, 32'd1);
    step();
    slv_aw_valid = 0; b_valid = 1; b_ready = 1;
    samp();
    check("aw_cnt_after_aw", 32'(dut.aw_cnt), 32'd1);
    step();
    b_valid = 0; b_ready = 0;
    samp();
    check("aw_cnt_after_b", 32'(dut.aw_cnt), 32'd0);

    // Rule table: overlapping idx1/idx2, lowest index wins
    program_rule(2'd0, 1'b1, 32'h8000_0000, 32'hF000_0000, 32'h2000_0000);
    program_rule(2'd1, 1'b1, 32'h4000_0000, 32'hF000_0000, 32'hA000_0000);
    program_rule(2'd2, 1'b1, 32'h4000_0000, 32'hFF00_0000, 32'hB000_0000);
    run_vecs(0, 3);
    program_rule(2'd1, 1'b0, 32'h4000_0000, 32'hF000_0000, 32'hA000_0000);
    program_rule(2'd3, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_0000);
    run_vecs(4, 7);

    // Drain: outstanding AR blocks the update until its R-last
    step();
    ar_addr = 32'h8000_0010; slv_ar_valid = 1; mst_ar_ready = 1;
    samp();
    check("drain_ar_pass", {31'd0, mst_ar_valid}, 32'd1);
    step();
    slv_ar_valid = 0;
    set_cfg(2'd0, 1'b1, 32'h8000_0000, 32'hF000_0000, 32'h3000_0000);
    samp();
    check("drain_ar_cnt", 32'(dut.ar_cnt), 32'd1);
    step();
    slv_ar_valid = 1; slv_aw_valid = 1; mst_aw_ready = 1;
    samp();
    check("drain_ar_blocked", {30'd0, mst_ar_valid, slv_ar_ready}, 32'd0);
    check("drain_aw_blocked", {30'd0, mst_aw_valid, slv_aw_ready}, 32'd0);
    check("drain_busy", {31'd0, busy}, 32'd1);
    step();
    samp();
    check("drain_no_ready", {31'd0, cfg_ready}, 32'd0);
    step();
    slv_ar_valid = 0; slv_aw_valid = 0; mst_aw_ready = 0;
    r_valid = 1; r_ready = 1; r_last = 1;
    samp();
    step();
    r_valid = 0; r_ready = 0; r_last = 0;
    samp();
    check("drain_ar_cnt_zero", 32'(dut.ar_cnt), 32'd0);
    check("drain_ready_not_yet", {31'd0, cfg_ready}, 32'd0);
    step();
    samp();
    check("drain_apply_ready", {31'd0, cfg_ready}, 32'd1);
    step();
    cfg_valid = 0; slv_ar_valid = 1; ar_addr = 32'h8000_0010;
    samp();
    check("resume_busy", {31'd0, busy}, 32'd0);
    check("resume_ar_valid", {31'd0, mst_ar_valid}, 32'd1);
    check("resume_new_rule", ar_addr_o, 32'h3000_0010);
    step();
    slv_ar_valid = 0; r_valid = 1; r_ready = 1; r_last = 1;
    step();
    r_valid = 0; r_ready = 0; r_last = 0;
    samp();
    check("resume_ar_cnt", 32'(dut.ar_cnt), 32'd0);

    // Stalled AW keeps valid asserted across the update request
    step();
    aw_addr = 32'h8000_0004; slv_aw_valid = 1; mst_aw_ready = 0;
    samp();
    check("hold_aw_valid0", {31'd0, mst_aw_valid}, 32'd1);
    step();
    set_cfg(2'd0, 1'b1, 32'h8000_0000, 32'hF000_0000, 32'h3000_0000);
    samp();
    check("hold_aw_valid1", {31'd0, mst_aw_valid}, 32'd1);
    step(); step();
    samp();
    check("hold_aw_valid2", {31'd0, mst_aw_valid}, 32'd1);
    check("hold_busy", {31'd0, busy}, 32'd1);
    check("hold_no_ready", {31'd0, cfg_ready}, 32'd0);
    step();
    mst_aw_ready = 1;
    samp();
    check("hold_slv_ready", {31'd0, slv_aw_ready}, 32'd1);
    step();
    samp();
    check("hold_closed", {31'd0, mst_aw_valid}, 32'd0);
    check("hold_aw_cnt", 32'(dut.aw_cnt), 32'd1);
    check("hold_no_ready2", {31'd0, cfg_ready}, 32'd0);
    step();
    slv_aw_valid = 0; mst_aw_ready = 0; b_valid = 1; b_ready = 1;
    step();
    b_valid = 0; b_ready = 0;
    wait_cfg("hold_cfg_handshake");

    // Outstanding limit of two reads, then reset in the middle of a drain
    step();
    ar_addr = 32'h0000_1000; slv_ar_valid = 1; mst_ar_ready = 1;
    samp();
    check("max_ar0_ready", {31'd0, slv_ar_ready}, 32'd1);
    step();
    samp();
    check("max_ar1_ready", {31'd0, slv_ar_ready}, 32'd1);
    step();
    samp();
    check("max_ar2_stall", {30'd0, mst_ar_valid, slv_ar_ready}, 32'd0);
    check("max_ar_cnt2", 32'(dut.ar_cnt), 32'd2);
    step();
    r_valid = 1; r_ready = 1; r_last = 1;
    samp();
    check("max_ar2_still", {31'd0, slv_ar_ready}, 32'd0);
    step();
    r_valid = 0; r_ready = 0; r_last = 0;
    samp();
    check("max_ar2_open", {31'd0, slv_ar_ready}, 32'd1);
    check("max_ar_cnt1", 32'(dut.ar_cnt), 32'd1);
    step();
    slv_ar_valid = 0;
    set_cfg(2'd2, 1'b1, 32'h0, 32'h0, 32'hDEAD_0000);
    step(); step();
    samp();
    check("rst_drain_busy", {31'd0, busy}, 32'd1);
    check("rst_drain_cnt", 32'(dut.ar_cnt), 32'd2);
    rst = 1'b1;
    ar_addr = 32'h8000_0010;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ar_cnt", 32'(dut.ar_cnt), 32'd0);
    check("midrst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    check("midrst_table_clear", ar_addr_o, 32'h8000_0010);
    step();
    cfg_valid = 0;
    samp();
    rst = 1'b0;
    step(); step();
    samp();
    check("post_rst_idle", {31'd0, busy}, 32'd0);
    check("post_rst_no_write", aw_addr_o, aw_addr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
